// File: rtl/dla_kpe_mac_seq.sv
// Job sequencer for one KPE multiplier: streams job_len operand pairs in, accumulates products.
// Latency: result MUL_LAT cycles after the last beat; out_valid holds until out_ready.
package dla_kpe_pkg;
  typedef enum logic [1:0] {
    PREC_IFMAP_16B = 2'd0,
    PREC_IFMAP_8B  = 2'd1
  } precision_ifmap_e;

  typedef enum logic [1:0] {
    PREC_WEIGHT_16B = 2'd0,
    PREC_WEIGHT_8B  = 2'd1
  } precision_weight_e;
endpackage

module dla_kpe_mac_seq
  import dla_kpe_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int LEN_W   = 12,
  parameter int ACC_W   = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_start,
  input  logic [LEN_W-1:0]  job_len,
  input  precision_ifmap_e  cfg_precision_ifmap,
  input  precision_weight_e cfg_precision_weight,
  output logic              job_busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_a,
  input  logic [15:0]       in_b,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  output logic              ctrl_kpe_mul_enable,
  output precision_ifmap_e  stgr_precision_ifmap,
  output precision_weight_e stgr_precision_weight,
  input  logic [41:0]       mul_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_psum_hi,
  output logic [ACC_W-1:0]  out_psum_lo
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [DW-1:0]     drain_q;
  precision_ifmap_e  prec_i_q;
  precision_weight_e prec_w_q;
  logic [ACC_W-1:0]  acc_hi_q, acc_lo_q;
  logic              start, beat, last_beat, drain_done, acc_en;

  assign start      = (state_q == IDLE) && job_start;
  assign beat       = in_valid && (state_q == RUN);
  assign last_beat  = beat && (cnt_q == len_q - 1'b1);
  assign drain_done = (drain_q == DW'(MUL_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d             = state_q;
    job_busy            = 1'b1;
    in_ready            = 1'b0;
    out_valid           = 1'b0;
    ctrl_kpe_mul_enable = 1'b0;
    case (state_q)
      IDLE: begin
        job_busy = 1'b0;
        if (job_start) state_d = (job_len == '0) ? DONE : RUN;
      end
      RUN: begin
        in_ready            = 1'b1;
        ctrl_kpe_mul_enable = 1'b1;
        if (last_beat) state_d = (MUL_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        ctrl_kpe_mul_enable = 1'b1;
        if (drain_done) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      cnt_q    <= '0;
      drain_q  <= '0;
      prec_i_q <= PREC_IFMAP_16B;
      prec_w_q <= PREC_WEIGHT_16B;
    end else begin
      drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
      if (start) begin
        len_q    <= job_len;
        cnt_q    <= '0;
        prec_i_q <= cfg_precision_ifmap;
        prec_w_q <= cfg_precision_weight;
      end else if (beat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // The operand register is the first multiplier stage, so the tag pipe is MUL_LAT deep.
  if (MUL_LAT == 0) begin : g_comb
    assign mul_a  = beat ? in_a : '0;
    assign mul_b  = beat ? in_b : '0;
    assign acc_en = beat;
  end else begin : g_pipe
    logic [15:0]        a_q, b_q;
    logic [MUL_LAT-1:0] tag_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q   <= '0;
        b_q   <= '0;
        tag_q <= '0;
      end else begin
        a_q   <= beat ? in_a : '0;
        b_q   <= beat ? in_b : '0;
        tag_q <= (tag_q << 1) | MUL_LAT'(beat);
      end
    end
    assign mul_a  = a_q;
    assign mul_b  = b_q;
    assign acc_en = tag_q[MUL_LAT-1];
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
    end else if (acc_en) begin
      if (prec_i_q == PREC_IFMAP_8B) begin
        acc_lo_q <= acc_lo_q + ACC_W'($signed(mul_y[15:0]));
        acc_hi_q <= acc_hi_q + ACC_W'($signed(mul_y[41:16]));
      end else begin
        acc_hi_q <= acc_hi_q + ACC_W'($signed(mul_y));
      end
    end
  end

  assign stgr_precision_ifmap  = prec_i_q;
  assign stgr_precision_weight = prec_w_q;
  assign out_psum_hi           = acc_hi_q;
  assign out_psum_lo           = acc_lo_q;

endmodule

// File: tb/tb_dla_kpe_mac_seq.sv
// Bench for dla_kpe_mac_seq with a behavioural MUL_LAT=3 multiplier and a psum scoreboard.
module tb_dla_kpe_mac_seq;
  import dla_kpe_pkg::*;

  localparam int ML = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_start;
  logic [11:0]       job_len;
  precision_ifmap_e  cfg_i;
  precision_weight_e cfg_w;
  logic              job_busy, in_valid, in_ready;
  logic [15:0]       in_a, in_b, mul_a, mul_b;
  logic              ctrl_kpe_mul_enable;
  precision_ifmap_e  stgr_i;
  precision_weight_e stgr_w;
  logic [41:0]       mul_y;
  logic              out_valid, out_ready;
  logic [47:0]       out_psum_hi, out_psum_lo;

  dla_kpe_mac_seq #(.MUL_LAT(ML), .LEN_W(12), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_len(job_len),
    .cfg_precision_ifmap(cfg_i), .cfg_precision_weight(cfg_w), .job_busy(job_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .ctrl_kpe_mul_enable(ctrl_kpe_mul_enable),
    .stgr_precision_ifmap(stgr_i), .stgr_precision_weight(stgr_w), .mul_y(mul_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psum_hi(out_psum_hi), .out_psum_lo(out_psum_lo)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: two stages after the DUT operand register.
  function automatic logic [41:0] mul_f(input logic [15:0] a, input logic [15:0] b,
                                        input precision_ifmap_e pi);
    logic signed [31:0] p;
    logic [15:0]        lo;
    logic [25:0]        hi;
    if (pi == PREC_IFMAP_8B) begin
      lo = 16'($signed(a[7:0]) * $signed(b[7:0]));
      hi = 26'($signed(a[15:8]) * $signed(b[7:0]));
      return {hi, lo};
    end
    p = $signed(a) * $signed(b);
    return 42'(p);
  endfunction

  logic [41:0] y1, y2;
  always @(posedge clk) begin
    if (ctrl_kpe_mul_enable) begin
      y1 <= mul_f(mul_a, mul_b, stgr_i);
      y2 <= y1;
    end
  end
  assign mul_y = y2;

  typedef struct packed {
    logic [47:0] hi;
    logic [47:0] lo;
  } exp_t;

  typedef struct {
    logic [11:0]       len;
    precision_ifmap_e  pi;
    precision_weight_e pw;
    logic [15:0]       a;
    logic [15:0]       b;
    logic [7:0]        vpat;
    int                stall;
    bit                lat;
    logic [47:0]       hi;
    logic [47:0]       lo;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input bit poke);
    int          sent, cyc, first, waitc, to;
    bit          en_seen, stable;
    logic [47:0] h, l;
    exp_t        e;
    @(negedge clk);
    job_start = 1'b1; job_len = v.len; cfg_i = v.pi; cfg_w = v.pw;
    in_a = v.a; in_b = v.b;
    sb_q.push_back('{hi: v.hi, lo: v.lo});
    @(negedge clk);
    job_start = 1'b0;
    sent = 0; cyc = 0; first = -1; to = 0; en_seen = 1'b0;
    while (sent < int'(v.len) && to < 1000) begin
      en_seen |= ctrl_kpe_mul_enable;
      in_valid = v.vpat[cyc % 8];
      if (poke) begin
        job_start = (sent == 1);
        if (sent == 1) begin
          job_len = 12'd7; cfg_i = PREC_IFMAP_8B; cfg_w = PREC_WEIGHT_8B;
        end
      end
      if (in_valid && in_ready) begin
        if (first < 0) first = cyc;
        sent++;
      end
      @(negedge clk);
      cyc++; to++;
    end
    in_valid = 1'b0; job_start = 1'b0;
    if (to >= 1000) check("beat_timeout", 64'(sent), 64'(v.len));
    waitc = 0;
    while (!out_valid && waitc < 100) begin
      en_seen |= ctrl_kpe_mul_enable;
      @(negedge clk);
      cyc++; waitc++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
    if (v.lat && first >= 0) check("latency", 64'(cyc - first), 64'(int'(v.len) + ML));
    if (v.len == 0) begin
      check("len0_delay", 64'(waitc), 64'd0);
      check("len0_enable", 64'(en_seen), 64'd0);
    end
    h = out_psum_hi; l = out_psum_lo; stable = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_psum_hi !== h || out_psum_lo !== l) stable = 1'b0;
    end
    if (v.stall > 0) check("stall_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    job_start = poke;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check("psum_hi", 64'(out_psum_hi), 64'(e.hi));
      check("psum_lo", 64'(out_psum_lo), 64'(e.lo));
    end
    @(negedge clk);
    out_ready = 1'b0; job_start = 1'b0;
    check("valid_after_hs", 64'(out_valid), 64'd0);
    check("busy_after_hs", 64'(job_busy), 64'd0);
  endtask

  vec_t vt[7];
  vec_t hv;

  initial begin
    rst = 1'b1; job_start = 1'b0; job_len = '0; cfg_i = PREC_IFMAP_16B;
    cfg_w = PREC_WEIGHT_16B; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    vt[0] = '{len: 4, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'd3, b: 16'hFFFE,
              vpat: 8'hFF, stall: 0, lat: 1, hi: -48'sd24, lo: 48'd0};
    vt[1] = '{len: 3, pi: PREC_IFMAP_8B, pw: PREC_WEIGHT_8B, a: 16'h0302, b: 16'h0005,
              vpat: 8'hFF, stall: 0, lat: 1, hi: 48'd45, lo: 48'd30};
    vt[2] = '{len: 1, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'h7FFF, b: 16'h7FFF,
              vpat: 8'hFF, stall: 0, lat: 1, hi: 48'h3FFF0001, lo: 48'd0};
    vt[3] = '{len: 2, pi: PREC_IFMAP_8B, pw: PREC_WEIGHT_8B, a: 16'h80FF, b: 16'h0003,
              vpat: 8'hFF, stall: 2, lat: 1, hi: -48'sd768, lo: -48'sd6};
    vt[4] = '{len: 2, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'hFFFF, b: 16'hFFFF,
              vpat: 8'hFF, stall: 0, lat: 1, hi: 48'd2, lo: 48'd0};
    vt[5] = '{len: 3, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'h8000, b: 16'h8000,
              vpat: 8'hFF, stall: 0, lat: 1, hi: 48'hC0000000, lo: 48'd0};
    vt[6] = '{len: 0, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'd9, b: 16'd9,
              vpat: 8'hFF, stall: 0, lat: 0, hi: 48'd0, lo: 48'd0};

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(job_busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_enable", 64'(ctrl_kpe_mul_enable), 64'd0);
    check("rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    check("rst_stgr", 64'({stgr_i, stgr_w}), 64'({PREC_IFMAP_16B, PREC_WEIGHT_16B}));
    check("rst_psum", 64'(out_psum_hi | out_psum_lo), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vt[i], 1'b0);

    // Gapped input stream with a long output stall.
    hv = '{len: 3, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'd5, b: 16'hFFFD,
           vpat: 8'b1111_1001, stall: 5, lat: 0, hi: -48'sd45, lo: 48'd0};
    run_job(hv, 1'b0);

    // Stray job_start pulses during RUN and on the handshake cycle.
    hv = '{len: 4, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'd2, b: 16'd9,
           vpat: 8'hFF, stall: 1, lat: 1, hi: 48'd72, lo: 48'd0};
    run_job(hv, 1'b1);

    // Abort a packed job with reset after some products have been accumulated.
    @(negedge clk);
    job_start = 1'b1; job_len = 12'd8; cfg_i = PREC_IFMAP_8B; cfg_w = PREC_WEIGHT_8B;
    in_a = 16'h0101; in_b = 16'h0001;
    @(negedge clk);
    job_start = 1'b0; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 64'(job_busy), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_enable", 64'(ctrl_kpe_mul_enable), 64'd0);
    check("mid_rst_mul_ab", 64'({mul_a, mul_b}), 64'd0);
    check("mid_rst_stgr", 64'({stgr_i, stgr_w}), 64'({PREC_IFMAP_16B, PREC_WEIGHT_16B}));
    check("mid_rst_psum", 64'(out_psum_hi | out_psum_lo), 64'd0);
    rst = 1'b0;
    hv = '{len: 1, pi: PREC_IFMAP_16B, pw: PREC_WEIGHT_16B, a: 16'd7, b: 16'd7,
           vpat: 8'hFF, stall: 0, lat: 1, hi: 48'd49, lo: 48'd0};
    run_job(hv, 1'b0);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
